gcm_ghash_ctrl: RTL and testbench
=================================

# gcm_ghash_ctrl

Sequencer in front of the `gcm_ghash` multiplier core for AES-GCM. Accepts a stream of 128-bit AAD and ciphertext blocks, zero-pads partial final blocks, and issues `init`/`next` to the core one block at a time. It counts AAD and ciphertext bit lengths and appends the final `len(A)||len(C)` block. It returns the complete GHASH value S for the tag stage.

## Interface
- No parameters; block width fixed at 128, length counters fixed at 64 bits.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  in  1  one-cycle pulse; begins a new message; ignored unless IDLE
- h_key  in  128  hash subkey H; sampled on accepted start
- len_only  in  1  sampled with start; 1 = A and C both empty, only the length block is hashed
- s_valid  in  1  input block valid
- s_ready  out  1  controller accepts the block this cycle
- s_data  in  128  block, byte 0 in bits [127:120]
- s_bytes  in  5  valid bytes in block, 1..16; 0 is treated as 16
- s_aad  in  1  1 = AAD block, 0 = ciphertext block
- s_last  in  1  final data block of the message
- core_init  out  1  one-cycle pulse to core: Y = x·H
- core_next  out  1  one-cycle pulse to core: Y = (Y ^ x)·H
- core_h0  out  128  registered H to core
- core_x  out  128  registered, padded block to core
- core_y  in  128  core result
- core_ready  in  1  core idle, core_y valid
- busy  out  1  high in every state except IDLE
- tag_valid  out  1  one-cycle pulse, tag_hash valid
- tag_hash  out  128  final GHASH S; holds until next tag_valid
- order_err  out  1  one-cycle pulse: AAD block after a ciphertext block

## Operation
- States: IDLE, WAIT_DATA, ISSUE, WAIT_CORE, LEN_ISSUE, LEN_WAIT, DONE.
- IDLE on start: latch h_key into core_h0, clear aad_bits/ct_bits/first/seen_ct, and set first=1.
  - len_only=1: go to LEN_ISSUE.
  - Otherwise: go to WAIT_DATA.
- WAIT_DATA: s_ready=1. On s_valid:
  - Register core_x = s_data with bytes at index ≥ s_bytes forced to 0.
  - Add 8·s_bytes to aad_bits if s_aad, else to ct_bits. Counters wrap modulo 2^64.
  - Set seen_ct when s_aad=0. Latch s_last.
  - Go to ISSUE.
- Order error: if s_aad=1 and seen_ct=1, the beat is consumed but not hashed. Pulse order_err and go to IDLE; no tag_valid.
- ISSUE: pulse core_init if first, else core_next. Clear first. Go to WAIT_CORE.
- WAIT_CORE: ignore core_ready on the first cycle (core ready-drop latency). Afterwards, when core_ready=1:
  - Latched s_last: go to LEN_ISSUE.
  - Otherwise: go to WAIT_DATA.
- LEN_ISSUE: core_x = {aad_bits, ct_bits}. Pulse core_init if first, else core_next. Go to LEN_WAIT.
- LEN_WAIT: same one-cycle blanking as WAIT_CORE. On core_ready=1, latch tag_hash=core_y and go to DONE.
- DONE: tag_valid=1 for one cycle, then IDLE.
- Partial blocks mid-stream (s_bytes<16 without s_last) are legal. Each is padded and counted as given.

## Timing
- Reset values: s_ready=0, core_init=0, core_next=0, core_h0=0, core_x=0, busy=0, tag_valid=0, tag_hash=0, order_err=0; state IDLE.
- Reset mid-operation: return to IDLE next edge and drop any in-flight core pulse. The core is reset by the same reset.
- start while busy has no effect.
- Per block: accept edge → ISSUE (1 cycle) → WAIT_CORE (≥2 cycles) → WAIT_DATA. Throughput is 1 block per (3 + core latency) cycles.
- Tag latency after the last core_ready: LEN_ISSUE + LEN_WAIT + core latency, then tag_valid on the DONE cycle.
- s_ready is combinational from state only, with no dependency on s_valid.
- Exactly one of core_init/core_next per hashed block. The length block is always issued. The first issued block of every message uses core_init.

## Test plan
- len_only=1, H=66e94bd4ef8a2c3b884cfa59ca342b2e → single core_init with core_x=0; tag_hash=00000000000000000000000000000000; tag_valid one pulse.
- One ciphertext block 0388dace60b6a392f328c2b971b2fe78 (s_bytes=16, s_last=1) with the same H → core_init, then core_next with core_x=0…0080; tag_hash matches the software GHASH model.
- Sequence of 2 AAD blocks and 3 CT blocks, the last CT with s_bytes=5 → last core_x has bytes 5..15 zero; length block={64'd256,64'd296}; one init, five nexts; tag matches the model.
- AAD, CT, then AAD → order_err pulse on the third accept, return to IDLE, no tag_valid, busy=0.
- Assert reset during WAIT_CORE → next cycle all outputs at reset values. A fresh start then completes normally.
- start pulsed during WAIT_DATA with s_valid=0 → ignored, state and counters unchanged. Stall s_valid for 10 cycles → no core pulses while stalled.

Source files
------------

// File: rtl/gcm_ghash_ctrl.sv
// gcm_ghash_ctrl: sequencer in front of the gcm_ghash multiplier core.
// Takes 128-bit AAD/ciphertext blocks, zero-pads partial blocks, issues
// init/next to the core one block at a time, counts AAD and ciphertext bit
// lengths and finally hashes the len(A)||len(C) block to produce GHASH S.
module gcm_ghash_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] h_key,
  input  logic         len_only,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic [4:0]   s_bytes,
  input  logic         s_aad,
  input  logic         s_last,
  output logic         core_init,
  output logic         core_next,
  output logic [127:0] core_h0,
  output logic [127:0] core_x,
  input  logic [127:0] core_y,
  input  logic         core_ready,
  output logic         busy,
  output logic         tag_valid,
  output logic [127:0] tag_hash,
  output logic         order_err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_LEN_ISSUE = 3'd4,
    ST_LEN_WAIT  = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic           blank_q, blank_d;
  logic           first_q, first_d;
  logic           seen_ct_q, seen_ct_d;
  logic           last_q, last_d;
  logic [63:0]    aad_bits_q, aad_bits_d;
  logic [63:0]    ct_bits_q, ct_bits_d;
  logic [127:0]   core_h0_q, core_h0_d;
  logic [127:0]   core_x_q, core_x_d;
  logic [127:0]   tag_hash_q, tag_hash_d;
  logic           core_init_q, core_init_d;
  logic           core_next_q, core_next_d;
  logic           busy_q, busy_d;
  logic           tag_valid_q, tag_valid_d;
  logic           order_err_q, order_err_d;

  logic           accept_s;
  logic           ord_err_s;
  logic           core_done_s;
  logic [4:0]     nbytes_s;
  logic [63:0]    bits_add_s;
  logic [127:0]   padded_s;

  // Keep bytes 0..nbytes-1 (byte 0 is the MSB byte) and zero the rest.
  function automatic logic [127:0] pad_block(input logic [127:0] blk,
                                             input logic [4:0]   nbytes);
    logic [127:0] res;
    res = 128'd0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < nbytes) begin
        res[127 - 8*i -: 8] = blk[127 - 8*i -: 8];
      end else begin
        res[127 - 8*i -: 8] = 8'h00;
      end
    end
    return res;
  endfunction

  // A byte count of 0 (or anything out of range) means a full block.
  assign nbytes_s    = ((s_bytes == 5'd0) || (s_bytes > 5'd16)) ? 5'd16 : s_bytes;
  assign bits_add_s  = {56'd0, nbytes_s, 3'b000};
  assign padded_s    = pad_block(s_data, nbytes_s);
  assign accept_s    = (state_q == ST_WAIT_DATA) && s_valid;
  assign ord_err_s   = accept_s && s_aad && seen_ct_q;
  // The first wait cycle is blanked: the core may not have dropped ready yet.
  assign core_done_s = !blank_q && core_ready;

  assign s_ready   = (state_q == ST_WAIT_DATA);
  assign core_init = core_init_q;
  assign core_next = core_next_q;
  assign core_h0   = core_h0_q;
  assign core_x    = core_x_q;
  assign busy      = busy_q;
  assign tag_valid = tag_valid_q;
  assign tag_hash  = tag_hash_q;
  assign order_err = order_err_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = len_only ? ST_LEN_ISSUE : ST_WAIT_DATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        if (ord_err_s) begin
          state_d = ST_IDLE;
        end else if (accept_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_WAIT_DATA;
        end
      end
      ST_ISSUE:     state_d = ST_WAIT_CORE;
      ST_WAIT_CORE: begin
        if (core_done_s) begin
          state_d = last_q ? ST_LEN_ISSUE : ST_WAIT_DATA;
        end else begin
          state_d = ST_WAIT_CORE;
        end
      end
      ST_LEN_ISSUE: state_d = ST_LEN_WAIT;
      ST_LEN_WAIT: begin
        if (core_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LEN_WAIT;
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; pulses are set on entry to their state.
  always_comb begin
    first_d     = first_q;
    seen_ct_d   = seen_ct_q;
    last_d      = last_q;
    aad_bits_d  = aad_bits_q;
    ct_bits_d   = ct_bits_q;
    core_h0_d   = core_h0_q;
    core_x_d    = core_x_q;
    tag_hash_d  = tag_hash_q;
    core_init_d = 1'b0;
    core_next_d = 1'b0;
    order_err_d = 1'b0;
    busy_d      = (state_d != ST_IDLE);
    tag_valid_d = (state_d == ST_DONE);
    blank_d     = ((state_d == ST_WAIT_CORE) || (state_d == ST_LEN_WAIT)) &&
                  (state_d != state_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          core_h0_d  = h_key;
          aad_bits_d = 64'd0;
          ct_bits_d  = 64'd0;
          seen_ct_d  = 1'b0;
          last_d     = 1'b0;
          first_d    = 1'b1;
          if (len_only) begin
            core_x_d    = 128'd0;
            core_init_d = 1'b1;
          end else begin
            core_x_d    = core_x_q;
          end
        end else begin
          first_d = first_q;
        end
      end
      ST_WAIT_DATA: begin
        if (ord_err_s) begin
          order_err_d = 1'b1;
        end else if (accept_s) begin
          core_x_d = padded_s;
          if (s_aad) begin
            aad_bits_d = aad_bits_q + bits_add_s;
          end else begin
            ct_bits_d  = ct_bits_q + bits_add_s;
            seen_ct_d  = 1'b1;
          end
          last_d      = s_last;
          core_init_d = first_q;
          core_next_d = !first_q;
        end else begin
          order_err_d = 1'b0;
        end
      end
      ST_ISSUE: begin
        first_d = 1'b0;
      end
      ST_WAIT_CORE: begin
        if (core_done_s && last_q) begin
          core_x_d    = {aad_bits_q, ct_bits_q};
          core_init_d = first_q;
          core_next_d = !first_q;
        end else begin
          core_x_d    = core_x_q;
        end
      end
      ST_LEN_ISSUE: begin
        first_d = 1'b0;
      end
      ST_LEN_WAIT: begin
        if (core_done_s) begin
          tag_hash_d = core_y;
        end else begin
          tag_hash_d = tag_hash_q;
        end
      end
      ST_DONE: begin
        first_d = first_q;
      end
      default: begin
        first_d = first_q;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q     <= 1'b0;
      first_q     <= 1'b0;
      seen_ct_q   <= 1'b0;
      last_q      <= 1'b0;
      aad_bits_q  <= 64'd0;
      ct_bits_q   <= 64'd0;
      core_h0_q   <= 128'd0;
      core_x_q    <= 128'd0;
      tag_hash_q  <= 128'd0;
      core_init_q <= 1'b0;
      core_next_q <= 1'b0;
      busy_q      <= 1'b0;
      tag_valid_q <= 1'b0;
      order_err_q <= 1'b0;
    end else begin
      blank_q     <= blank_d;
      first_q     <= first_d;
      seen_ct_q   <= seen_ct_d;
      last_q      <= last_d;
      aad_bits_q  <= aad_bits_d;
      ct_bits_q   <= ct_bits_d;
      core_h0_q   <= core_h0_d;
      core_x_q    <= core_x_d;
      tag_hash_q  <= tag_hash_d;
      core_init_q <= core_init_d;
      core_next_q <= core_next_d;
      busy_q      <= busy_d;
      tag_valid_q <= tag_valid_d;
      order_err_q <= order_err_d;
    end
  end

endmodule

// File: tb/tb_gcm_ghash_ctrl.sv
// tb_gcm_ghash_ctrl: scoreboard bench for gcm_ghash_ctrl with a behavioural
// GHASH core. Expected core_x/init selections and tags are pushed when a
// message is driven and popped when the DUT pulses the core / raises tag_valid.
module tb_gcm_ghash_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] h_key;
  logic         len_only;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic [4:0]   s_bytes;
  logic         s_aad;
  logic         s_last;
  logic         core_init;
  logic         core_next;
  logic [127:0] core_h0;
  logic [127:0] core_x;
  logic [127:0] core_y;
  logic         core_ready;
  logic         busy;
  logic         tag_valid;
  logic [127:0] tag_hash;
  logic         order_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_x_q   [$];
  bit           exp_init_q[$];
  logic [127:0] exp_tag_q [$];
  logic [127:0] exp_h;

  int           lat_cfg = 2;
  int           cnt = 0;
  int           pulse_cnt = 0;
  int           tag_cnt = 0;
  logic [127:0] y_m;

  logic [127:0] bd [0:7];
  logic [4:0]   bb [0:7];
  bit           ba [0:7];

  localparam logic [127:0] H1 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C1 = 128'h0388dace60b6a392f328c2b971b2fe78;

  gcm_ghash_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .h_key(h_key), .len_only(len_only),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_bytes(s_bytes),
    .s_aad(s_aad), .s_last(s_last), .core_init(core_init), .core_next(core_next),
    .core_h0(core_h0), .core_x(core_x), .core_y(core_y), .core_ready(core_ready),
    .busy(busy), .tag_valid(tag_valid), .tag_hash(tag_hash), .order_err(order_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // GF(2^128) multiply in GCM bit order.
  function automatic logic [127:0] gf_mult(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z, v;
    z = 128'd0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      if (v[0]) v = (v >> 1) ^ {8'he1, 120'd0};
      else      v = v >> 1;
    end
    return z;
  endfunction

  function automatic logic [127:0] pad_ref(input logic [127:0] d, input logic [4:0] b);
    int n;
    logic [127:0] m;
    n = (b == 5'd0) ? 16 : int'(b);
    m = {128{1'b1}} << (8 * (16 - n));
    return d & m;
  endfunction

  // Behavioural core: samples pulses mid-cycle, answers after lat_cfg cycles.
  always @(negedge clk) begin
    if (reset) begin
      core_ready = 1'b1;
      core_y     = 128'd0;
      y_m        = 128'd0;
      cnt        = 0;
    end else begin
      if (core_init && core_next) chk("both_pulses", 128'd1, 128'd0);
      if (core_init || core_next) begin
        pulse_cnt++;
        if (exp_x_q.size() == 0) begin
          chk("unexpected_pulse", 128'd0, 128'd1);
        end else begin
          chk("core_x", core_x, exp_x_q.pop_front());
          chk("init_sel", 128'(core_init), 128'(exp_init_q.pop_front()));
          chk("core_h0", core_h0, exp_h);
        end
        y_m        = core_init ? gf_mult(core_x, core_h0) : gf_mult(y_m ^ core_x, core_h0);
        core_ready = 1'b0;
        cnt        = lat_cfg;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_y     = y_m;
          core_ready = 1'b1;
        end
      end
    end
  end

  // Tag monitor.
  always @(negedge clk) begin
    if (!reset && tag_valid) begin
      tag_cnt++;
      if (exp_tag_q.size() == 0) chk("unexpected_tag", 128'd0, 128'd1);
      else                       chk("tag_hash", tag_hash, exp_tag_q.pop_front());
    end
  end

  // Push expectations for a complete message held in bd/bb/ba.
  task automatic push_msg(input logic [127:0] h, input int n, input bit lo);
    logic [127:0] y, x;
    logic [63:0]  a, c;
    bit           first;
    int           nb;
    y = 128'd0; a = 64'd0; c = 64'd0; first = 1'b1;
    if (!lo) begin
      for (int i = 0; i < n; i++) begin
        x = pad_ref(bd[i], bb[i]);
        exp_x_q.push_back(x);
        exp_init_q.push_back(first);
        y = first ? gf_mult(x, h) : gf_mult(y ^ x, h);
        first = 1'b0;
        nb = (bb[i] == 5'd0) ? 16 : int'(bb[i]);
        if (ba[i]) a = a + 64'(8 * nb);
        else       c = c + 64'(8 * nb);
      end
    end
    x = {a, c};
    exp_x_q.push_back(x);
    exp_init_q.push_back(first);
    y = first ? gf_mult(x, h) : gf_mult(y ^ x, h);
    exp_tag_q.push_back(y);
  endtask

  task automatic do_start(input logic [127:0] h, input bit lo);
    start = 1'b1; h_key = h; len_only = lo;
    @(posedge clk); #1;
    start = 1'b0; len_only = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] d, input logic [4:0] b, input bit a, input bit l);
    int k;
    s_valid = 1'b1; s_data = d; s_bytes = b; s_aad = a; s_last = l;
    k = 0;
    while (!s_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (s_ready) begin
      @(posedge clk); #1;
    end else begin
      chk("s_ready_timeout", 128'd0, 128'd1);
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_tag();
    int k, t0;
    t0 = tag_cnt; k = 0;
    while (tag_cnt == t0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    if (tag_cnt == t0) chk("tag_timeout", 128'd0, 128'd1);
    @(negedge clk);
    chk("tag_one_pulse", 128'(tag_valid), 128'd0);
    chk("busy_after_tag", 128'(busy), 128'd0);
    @(posedge clk); #1;
  endtask

  task automatic run_msg(input logic [127:0] h, input int n, input bit lo);
    exp_h = h;
    push_msg(h, n, lo);
    do_start(h, lo);
    if (!lo) begin
      for (int i = 0; i < n; i++) send_block(bd[i], bb[i], ba[i], (i == n - 1));
    end
    wait_tag();
    chk("queues_drained", 128'(exp_x_q.size()), 128'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_ready"},   128'(s_ready),   128'd0);
    chk({tag, "_core_init"}, 128'(core_init), 128'd0);
    chk({tag, "_core_next"}, 128'(core_next), 128'd0);
    chk({tag, "_core_h0"},   core_h0,         128'd0);
    chk({tag, "_core_x"},    core_x,          128'd0);
    chk({tag, "_busy"},      128'(busy),      128'd0);
    chk({tag, "_tag_valid"}, 128'(tag_valid), 128'd0);
    chk({tag, "_tag_hash"},  tag_hash,        128'd0);
    chk({tag, "_order_err"}, 128'(order_err), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    reset = 1'b1; start = 1'b0; h_key = 128'd0; len_only = 1'b0;
    s_valid = 1'b0; s_data = 128'd0; s_bytes = 5'd0; s_aad = 1'b0; s_last = 1'b0;
    exp_h = 128'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Length-only message: single init with x = 0, tag 0.
    lat_cfg = 2;
    run_msg(H1, 0, 1'b1);

    // One full ciphertext block.
    lat_cfg = 3;
    bd[0] = C1; bb[0] = 5'd16; ba[0] = 1'b0;
    run_msg(H1, 1, 1'b0);

    // Two AAD blocks and three CT blocks, the last one 5 bytes.
    lat_cfg = 4;
    for (int i = 0; i < 5; i++) begin
      bd[i] = {$urandom, $urandom, $urandom, $urandom};
      bb[i] = 5'd16;
      ba[i] = (i < 2);
    end
    bb[4] = 5'd5;
    run_msg(H1, 5, 1'b0);

    // AAD, CT, then AAD: order error, no tag.
    lat_cfg = 1;
    exp_h = H1 ^ 128'h1;
    bd[0] = {$urandom, $urandom, $urandom, $urandom};
    bd[1] = {$urandom, $urandom, $urandom, $urandom};
    bd[2] = {$urandom, $urandom, $urandom, $urandom};
    exp_x_q.push_back(bd[0]); exp_init_q.push_back(1'b1);
    exp_x_q.push_back(bd[1]); exp_init_q.push_back(1'b0);
    do_start(exp_h, 1'b0);
    send_block(bd[0], 5'd16, 1'b1, 1'b0);
    send_block(bd[1], 5'd16, 1'b0, 1'b0);
    send_block(bd[2], 5'd16, 1'b1, 1'b0);
    @(negedge clk);
    chk("order_err_pulse", 128'(order_err), 128'd1);
    chk("order_err_busy", 128'(busy), 128'd0);
    chk("order_err_s_ready", 128'(s_ready), 128'd0);
    @(negedge clk);
    chk("order_err_width", 128'(order_err), 128'd0);
    chk("order_err_queue", 128'(exp_x_q.size()), 128'd0);
    @(posedge clk); #1;

    // Reset while in WAIT_CORE, then a fresh message.
    lat_cfg = 8;
    exp_h = H1;
    bd[0] = {$urandom, $urandom, $urandom, $urandom};
    exp_x_q.push_back(bd[0]); exp_init_q.push_back(1'b1);
    do_start(H1, 1'b0);
    send_block(bd[0], 5'd16, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    lat_cfg = 2;
    bd[0] = {$urandom, $urandom, $urandom, $urandom}; bb[0] = 5'd16; ba[0] = 1'b0;
    run_msg(H1, 1, 1'b0);

    // start ignored while busy, 10-cycle stall, mid-stream partial AAD block.
    lat_cfg = 3;
    exp_h = ~H1;
    bd[0] = {$urandom, $urandom, $urandom, $urandom}; bb[0] = 5'd3;  ba[0] = 1'b1;
    bd[1] = {$urandom, $urandom, $urandom, $urandom}; bb[1] = 5'd0;  ba[1] = 1'b0;
    push_msg(exp_h, 2, 1'b0);
    do_start(exp_h, 1'b0);
    do_start(H1, 1'b1);
    p0 = pulse_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_no_pulse", 128'(pulse_cnt), 128'(p0));
    chk("stall_busy", 128'(busy), 128'd1);
    chk("stall_s_ready", 128'(s_ready), 128'd1);
    chk("stall_h0_kept", core_h0, exp_h);
    send_block(bd[0], bb[0], ba[0], 1'b0);
    send_block(bd[1], bb[1], ba[1], 1'b1);
    wait_tag();
    chk("stall_queues_drained", 128'(exp_x_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
